// File: rtl/lock_arbiter_rr.sv
// -----------------------------------------------------------------------------
// lock_arbiter_rr
//   Round-robin spin-lock arbiter for several cores sharing one SharedRAM.
//   Grants exclusive lock ownership to one core at a time, drives a one-hot
//   go vector, gates per-core RAM write enables while the lock is held, and
//   force-releases a lock held for MAX_HOLD consecutive cycles.
//
// Ports
//   clk       rising-edge clock
//   rst       asynchronous, active-high reset
//   lock_req  per-core request code, core k at [2k+1:2k]
//             (0 none, 1 acquire, 2 release, 3 none)
//   wren_in   per-core RAM write enable from the cores
//   wren_out  write enable to SharedRAM (only the owner passes while held)
//   go        one-hot grant, bit k high while core k owns the lock
//   owner     0 = free, k+1 = core k owns the lock
//   timeout   one-cycle pulse following a forced release
// -----------------------------------------------------------------------------
module lock_arbiter_rr #(
  parameter int NUM_CORES = 2,    // 2..8
  parameter int OWNER_W   = 2,    // 2**OWNER_W >= NUM_CORES+1
  parameter int MAX_HOLD  = 255,  // 0 disables the timeout
  parameter int HOLD_W    = 8     // must be able to hold MAX_HOLD
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [2*NUM_CORES-1:0] lock_req,
  input  logic [NUM_CORES-1:0]   wren_in,
  output logic [NUM_CORES-1:0]   wren_out,
  output logic [NUM_CORES-1:0]   go,
  output logic [OWNER_W-1:0]     owner,
  output logic                   timeout
);

  typedef enum logic [1:0] {
    ST_FREE     = 2'd0,
    ST_HELD     = 2'd1,
    ST_COOLDOWN = 2'd2
  } state_e;

  localparam logic [1:0]        CODE_ACQ   = 2'd1;
  localparam logic [1:0]        CODE_REL   = 2'd2;
  localparam logic [HOLD_W-1:0] HOLD_SAT   = '1;
  // Last hold count before the forced release; meaningless when MAX_HOLD == 0.
  localparam logic [HOLD_W-1:0] HOLD_LIMIT = HOLD_W'(MAX_HOLD - 1);

  state_e              state_q, state_d;
  logic [OWNER_W-1:0]  owner_q, owner_d;
  logic [OWNER_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
  logic                timeout_q, timeout_d;

  logic                owner_rel;
  logic                found;
  int                  idx;

  // Grant decode straight off the owner register. An out-of-range owner
  // decodes to no grant, which also makes the write path pass-through.
  always_comb begin
    go        = '0;
    owner_rel = 1'b0;
    for (int k = 0; k < NUM_CORES; k++) begin
      go[k] = (owner_q == OWNER_W'(k + 1));
      if (go[k] && lock_req[2*k +: 2] == CODE_REL) owner_rel = 1'b1;
    end
    wren_out = (|go) ? (wren_in & go) : wren_in;
  end

  // NOTE: every signal written here gets a default before the case so that no
  // path leaves a value unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    rr_ptr_d   = rr_ptr_q;
    hold_cnt_d = hold_cnt_q;
    timeout_d  = 1'b0;
    found      = 1'b0;
    idx        = 0;

    case (state_q)
      ST_FREE: begin
        // Scan starting at rr_ptr, wrapping; the first acquirer wins.
        for (int i = 0; i < NUM_CORES; i++) begin
          idx = int'(rr_ptr_q) + i;
          if (idx >= NUM_CORES) idx = idx - NUM_CORES;
          if (!found && lock_req[2*idx +: 2] == CODE_ACQ) begin
            found      = 1'b1;
            state_d    = ST_HELD;
            owner_d    = OWNER_W'(idx + 1);
            rr_ptr_d   = (idx + 1 == NUM_CORES) ? '0 : OWNER_W'(idx + 1);
            hold_cnt_d = '0;
          end
        end
      end

      ST_HELD: begin
        hold_cnt_d = (hold_cnt_q == HOLD_SAT) ? hold_cnt_q : hold_cnt_q + 1'b1;
        // A voluntary release takes priority over a timeout in the same cycle.
        if (owner_rel) begin
          owner_d = '0;
          state_d = ST_COOLDOWN;
        end else if (MAX_HOLD != 0 && hold_cnt_q == HOLD_LIMIT) begin
          owner_d   = '0;
          state_d   = ST_COOLDOWN;
          timeout_d = 1'b1;
        end
      end

      // One dead cycle so the releasing core cannot grab the lock back
      // before the round-robin pointer lets a waiting core in.
      ST_COOLDOWN: state_d = ST_FREE;

      default: begin
        state_d = ST_FREE;
        owner_d = '0;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of the others, independent of evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_FREE;
      owner_q    <= '0;
      rr_ptr_q   <= '0;
      hold_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      rr_ptr_q   <= rr_ptr_d;
      hold_cnt_q <= hold_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  assign owner   = owner_q;
  assign timeout = timeout_q;

endmodule

// File: tb/tb_lock_arbiter_rr.sv
// -----------------------------------------------------------------------------
// tb_lock_arbiter_rr
//   Self-checking bench for lock_arbiter_rr with three cores and a short
//   hold limit. A behavioural model (owner index, elapsed hold cycles,
//   next-start core) tracks the expected lock state; a compare process checks
//   every DUT output against it at each falling edge. Directed scenarios with
//   literal expectations pin the model, then randomized traffic (including
//   occasional asynchronous resets) exercises the rest.
// -----------------------------------------------------------------------------
module tb_lock_arbiter_rr;

  localparam int N  = 3;
  localparam int OW = 2;
  localparam int MH = 4;
  localparam int HW = 3;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [2*N-1:0] lock_req = '0;
  logic [N-1:0]   wren_in = '0;
  logic [N-1:0]   wren_out;
  logic [N-1:0]   go;
  logic [OW-1:0]  owner;
  logic           timeout;

  int n_checks = 0;
  int n_fail   = 0;

  lock_arbiter_rr #(
    .NUM_CORES (N),
    .OWNER_W   (OW),
    .MAX_HOLD  (MH),
    .HOLD_W    (HW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .lock_req (lock_req),
    .wren_in  (wren_in),
    .wren_out (wren_out),
    .go       (go),
    .owner    (owner),
    .timeout  (timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic int code_of(input int c);
    return int'(lock_req[2*c +: 2]);
  endfunction

  // ---------------- behavioural model ----------------
  int m_owner = 0;   // 0 free, else core index + 1
  bit m_cool  = 0;   // dead cycle after any release
  int m_next  = 0;   // core the next search starts from
  int m_held  = 0;   // completed cycles the current owner has held the lock
  bit m_to    = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_owner = 0; m_cool = 0; m_next = 0; m_held = 0; m_to = 0;
    end else begin
      m_to = 0;
      if (m_cool) begin
        m_cool = 0;
      end else if (m_owner == 0) begin
        for (int i = 0; i < N; i++) begin
          int c;
          c = (m_next + i) % N;
          if (code_of(c) == 1) begin
            m_owner = c + 1;
            m_next  = (c + 1) % N;
            m_held  = 0;
            break;
          end
        end
      end else begin
        m_held++;
        if (code_of(m_owner - 1) == 2) begin
          m_owner = 0; m_cool = 1;
        end else if (MH != 0 && m_held == MH) begin
          m_owner = 0; m_cool = 1; m_to = 1;
        end
      end
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    logic [N-1:0] exp_go;
    logic [N-1:0] exp_wren;
    exp_go = '0;
    if (m_owner != 0) exp_go[m_owner-1] = 1'b1;
    exp_wren = (m_owner == 0) ? wren_in : (wren_in & exp_go);
    check("model_owner",   32'(owner),    32'(m_owner));
    check("model_go",      32'(go),       32'(exp_go));
    check("model_wren",    32'(wren_out), 32'(exp_wren));
    check("model_timeout", 32'(timeout),  32'(m_to));
  end

  // ---------------- stimulus ----------------
  task automatic next_cycle();
    @(posedge clk);
    #2;
  endtask

  task automatic set_code(input int c, input logic [1:0] code);
    lock_req[2*c +: 2] = code;
  endtask

  initial begin
    wren_in = 3'b101;
    #12;
    check("rst_owner", 32'(owner), 0);
    check("rst_go", 32'(go), 0);
    check("rst_timeout", 32'(timeout), 0);
    check("rst_wren_pass", 32'(wren_out), 32'h5);
    rst = 1'b0;

    // 1: single acquire, write gating
    set_code(0, 2'd1); wren_in = 3'b011;
    next_cycle();
    check("t1_owner", 32'(owner), 1);
    check("t1_go", 32'(go), 32'h1);
    check("t1_wren", 32'(wren_out), 32'h1);
    set_code(0, 2'd2);
    next_cycle();
    check("t1_cool_owner", 32'(owner), 0);
    check("t1_cool_wren", 32'(wren_out), 32'h3);
    set_code(0, 2'd0);
    next_cycle();

    // 2: round robin between two contending cores
    rst = 1'b1; #1; rst = 1'b0;
    set_code(0, 2'd1); set_code(1, 2'd1);
    next_cycle();
    check("t2_first", 32'(owner), 1);
    set_code(0, 2'd2);
    next_cycle();
    check("t2_cool", 32'(owner), 0);
    set_code(0, 2'd1);
    next_cycle();
    check("t2_free", 32'(owner), 0);
    next_cycle();
    check("t2_core1", 32'(owner), 2);
    check("t2_core1_go", 32'(go), 32'h2);
    set_code(1, 2'd2);
    next_cycle();
    check("t2_cool2", 32'(owner), 0);
    set_code(1, 2'd1);
    next_cycle();
    next_cycle();
    check("t2_back_to_core0", 32'(owner), 1);

    // 3: release from a non-owner is ignored; owner releases on its 4th cycle
    set_code(0, 2'd0); set_code(1, 2'd2);
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      check("t3_owner_kept", 32'(owner), 1);
      check("t3_go_kept", 32'(go), 32'h1);
    end
    set_code(1, 2'd0); set_code(0, 2'd2);
    next_cycle();
    check("t3_release_owner", 32'(owner), 0);
    check("t3_release_no_timeout", 32'(timeout), 0);
    set_code(0, 2'd0);
    next_cycle();

    // 4: forced release after MAX_HOLD cycles
    set_code(1, 2'd1);
    next_cycle();
    check("t4_grant", 32'(owner), 2);
    set_code(1, 2'd0);
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      check("t4_held", 32'(owner), 2);
      check("t4_no_timeout_yet", 32'(timeout), 0);
    end
    next_cycle();
    check("t4_forced_owner", 32'(owner), 0);
    check("t4_timeout_pulse", 32'(timeout), 1);
    next_cycle();
    check("t4_timeout_clear", 32'(timeout), 0);
    next_cycle();

    // 5: release on the last allowed cycle beats the timeout
    set_code(1, 2'd1);
    next_cycle();
    check("t5_grant", 32'(owner), 2);
    set_code(1, 2'd0);
    for (int i = 0; i < 3; i++) next_cycle();
    check("t5_still_held", 32'(owner), 2);
    set_code(1, 2'd2);
    next_cycle();
    check("t5_owner", 32'(owner), 0);
    check("t5_no_timeout", 32'(timeout), 0);
    set_code(1, 2'd0);
    next_cycle();

    // 6: asynchronous reset in the middle of a held lock
    set_code(0, 2'd1); wren_in = 3'b111;
    next_cycle();
    check("t6_grant", 32'(owner), 1);
    check("t6_gated", 32'(wren_out), 32'h1);
    set_code(0, 2'd0);
    #1 rst = 1'b1;
    #1;
    check("t6_async_owner", 32'(owner), 0);
    check("t6_async_go", 32'(go), 0);
    check("t6_async_wren", 32'(wren_out), 32'h7);
    rst = 1'b0;

    // Randomized traffic
    for (int cyc = 0; cyc < 2000; cyc++) begin
      next_cycle();
      lock_req = (2*N)'($urandom);
      wren_in  = N'($urandom);
      if ($urandom_range(0, 299) == 0) begin
        #1 rst = 1'b1;
        #1 rst = 1'b0;
      end
    end
    next_cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
